// File: rtl/vector_pkg.sv
// ---------------------------------------------------------------------------
// vector_pkg
// Shared types and constants for the vector line engine.
//   vle_state_t : engine state encoding. The SETTLE state is present only
//                 when VECTOR_SETTLE_EN is defined.
//   VLE_COORD_W : default coordinate / DAC code width.
//   VLE_ERR_W   : signed Bresenham error width. Two bits wider than the
//                 coordinates, so a full-scale line cannot overflow it.
// ---------------------------------------------------------------------------
package vector_pkg;

  localparam int VLE_COORD_W = 12;
  localparam int VLE_ERR_W   = VLE_COORD_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_JUMP   = 2'd2
`ifdef VECTOR_SETTLE_EN
    ,
    ST_SETTLE = 2'd3
`endif
  } vle_state_t;

endpackage

// File: rtl/bresenham_step.sv
// ---------------------------------------------------------------------------
// bresenham_step
// One purely combinational Bresenham step. Given the running error term,
// the signed deltas and step directions, it returns the next beam position
// and the next error term. An X step and a Y step can both happen in one
// step, which gives a diagonal move.
//   err      in  ERR_W    running error (signed)
//   dx       in  ERR_W    |tx-cx| (signed, >= 0)
//   dy       in  ERR_W    -|ty-cy| (signed, <= 0)
//   sx_neg   in  1        X steps toward smaller codes when set
//   sy_neg   in  1        Y steps toward smaller codes when set
//   cur_x/y  in  COORD_W  current beam position
//   next_x/y out COORD_W  position after this step
//   next_err out ERR_W    error after this step
// ---------------------------------------------------------------------------
module bresenham_step
  import vector_pkg::*;
#(
  parameter int COORD_W = VLE_COORD_W,
  parameter int ERR_W   = VLE_ERR_W
) (
  input  logic signed [ERR_W-1:0]   err,
  input  logic signed [ERR_W-1:0]   dx,
  input  logic signed [ERR_W-1:0]   dy,
  input  logic                      sx_neg,
  input  logic                      sy_neg,
  input  logic        [COORD_W-1:0] cur_x,
  input  logic        [COORD_W-1:0] cur_y,
  output logic        [COORD_W-1:0] next_x,
  output logic        [COORD_W-1:0] next_y,
  output logic signed [ERR_W-1:0]   next_err
);

  logic signed [ERR_W:0] e2;
  logic signed [ERR_W:0] dx_ext;
  logic signed [ERR_W:0] dy_ext;
  logic                  step_x;
  logic                  step_y;

  // e2 needs one extra bit so that doubling the error cannot overflow.
  // Both step decisions use the same e2, taken from the error before
  // either update is applied.
  always_comb begin
    e2     = {err, 1'b0};
    dx_ext = {dx[ERR_W-1], dx};
    dy_ext = {dy[ERR_W-1], dy};
    step_x = (e2 >= dy_ext);
    step_y = (e2 <= dx_ext);

    next_err = err;
    if (step_x) next_err = next_err + dy;
    if (step_y) next_err = next_err + dx;

    next_x = cur_x;
    if (step_x) next_x = sx_neg ? (cur_x - COORD_W'(1)) : (cur_x + COORD_W'(1));

    next_y = cur_y;
    if (step_y) next_y = sy_neg ? (cur_y - COORD_W'(1)) : (cur_y + COORD_W'(1));
  end

endmodule

// File: rtl/vector_line_engine.sv
// ---------------------------------------------------------------------------
// vector_line_engine
// Responder for the point-command interface. Each accepted request either
// jumps the beam, blanked, to (x,y) or draws a lit Bresenham line there
// from the current position. All outputs are registered.
//   clk      in  1        system clock, rising edge
//   reset    in  1        asynchronous reset, active low
//   x, y     in  COORD_W  target coordinate, sampled on accept
//   draw     in  1        draw request (lit line to target)
//   jump     in  1        jump request (blanked move); wins over draw
//   ready    out 1        idle and able to accept a request
//   dac_x/y  out COORD_W  current beam DAC codes
//   beam_on  out 1        beam unblank enable
// Optional feature: define VECTOR_SETTLE_EN to hold the beam blanked for
// SETTLE_CYCLES after every jump, so the deflection amplifiers can settle.
// ---------------------------------------------------------------------------
module vector_line_engine
  import vector_pkg::*;
#(
  parameter int COORD_W       = VLE_COORD_W,
  parameter int STEP_DIV      = 1,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               draw,
  input  logic               jump,
  output logic               ready,
  output logic [COORD_W-1:0] dac_x,
  output logic [COORD_W-1:0] dac_y,
  output logic               beam_on
);

  localparam int ERR_W = COORD_W + 2;
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  vle_state_t               state, state_nxt;
  logic                     ready_nxt;
  logic                     beam_nxt;
  logic [COORD_W-1:0]       dac_x_nxt, dac_y_nxt;
  logic [COORD_W-1:0]       tx, ty, tx_nxt, ty_nxt;
  logic signed [ERR_W-1:0]  err, err_nxt;
  logic signed [ERR_W-1:0]  dx_r, dx_nxt;
  logic signed [ERR_W-1:0]  dy_r, dy_nxt;
  logic                     sx_neg, sx_neg_nxt;
  logic                     sy_neg, sy_neg_nxt;
  logic [DIV_W-1:0]         div_cnt, div_nxt;
  logic [COORD_W-1:0]       abs_x, abs_y;
  logic [COORD_W-1:0]       step_x, step_y;
  logic signed [ERR_W-1:0]  step_err;
  logic                     at_target;

`ifdef VECTOR_SETTLE_EN
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  logic [SET_W-1:0] settle_cnt, settle_nxt;
`endif

  bresenham_step #(
    .COORD_W (COORD_W),
    .ERR_W   (ERR_W)
  ) u_step (
    .err      (err),
    .dx       (dx_r),
    .dy       (dy_r),
    .sx_neg   (sx_neg),
    .sy_neg   (sy_neg),
    .cur_x    (dac_x),
    .cur_y    (dac_y),
    .next_x   (step_x),
    .next_y   (step_y),
    .next_err (step_err)
  );

  // State and datapath registers. Reset drops everything straight back to
  // the idle, blanked, origin condition, aborting any line in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ready      <= 1'b1;
      beam_on    <= 1'b0;
      dac_x      <= '0;
      dac_y      <= '0;
      tx         <= '0;
      ty         <= '0;
      err        <= '0;
      dx_r       <= '0;
      dy_r       <= '0;
      sx_neg     <= 1'b0;
      sy_neg     <= 1'b0;
      div_cnt    <= '0;
`ifdef VECTOR_SETTLE_EN
      settle_cnt <= '0;
`endif
    end else begin
      state      <= state_nxt;
      ready      <= ready_nxt;
      beam_on    <= beam_nxt;
      dac_x      <= dac_x_nxt;
      dac_y      <= dac_y_nxt;
      tx         <= tx_nxt;
      ty         <= ty_nxt;
      err        <= err_nxt;
      dx_r       <= dx_nxt;
      dy_r       <= dy_nxt;
      sx_neg     <= sx_neg_nxt;
      sy_neg     <= sy_neg_nxt;
      div_cnt    <= div_nxt;
`ifdef VECTOR_SETTLE_EN
      settle_cnt <= settle_nxt;
`endif
    end
  end

  // Next-state and next-output logic. ready is only ever high in IDLE, so
  // requests arriving while busy fall through and are lost. A draw only
  // evaluates a step once every STEP_DIV cycles. The "arrived" check comes
  // before stepping, so the final point is held lit for one full step time.
  always_comb begin
    state_nxt  = state;
    ready_nxt  = ready;
    beam_nxt   = beam_on;
    dac_x_nxt  = dac_x;
    dac_y_nxt  = dac_y;
    tx_nxt     = tx;
    ty_nxt     = ty;
    err_nxt    = err;
    dx_nxt     = dx_r;
    dy_nxt     = dy_r;
    sx_neg_nxt = sx_neg;
    sy_neg_nxt = sy_neg;
    div_nxt    = div_cnt;
`ifdef VECTOR_SETTLE_EN
    settle_nxt = settle_cnt;
`endif

    abs_x     = (x >= dac_x) ? (x - dac_x) : (dac_x - x);
    abs_y     = (y >= dac_y) ? (y - dac_y) : (dac_y - y);
    at_target = (dac_x == tx) && (dac_y == ty);

    case (state)
      ST_IDLE: begin
        if (ready && jump) begin
          dac_x_nxt = x;
          dac_y_nxt = y;
          tx_nxt    = x;
          ty_nxt    = y;
          beam_nxt  = 1'b0;
          ready_nxt = 1'b0;
          state_nxt = ST_JUMP;
        end else if (ready && draw) begin
          tx_nxt     = x;
          ty_nxt     = y;
          dx_nxt     = $signed({2'b00, abs_x});
          dy_nxt     = -$signed({2'b00, abs_y});
          err_nxt    = dx_nxt + dy_nxt;
          sx_neg_nxt = (x < dac_x);
          sy_neg_nxt = (y < dac_y);
          div_nxt    = '0;
          beam_nxt   = 1'b1;
          ready_nxt  = 1'b0;
          state_nxt  = ST_DRAW;
        end
      end

      ST_DRAW: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (at_target) begin
            beam_nxt  = 1'b0;
            ready_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            dac_x_nxt = step_x;
            dac_y_nxt = step_y;
            err_nxt   = step_err;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end

      ST_JUMP: begin
`ifdef VECTOR_SETTLE_EN
        if (SETTLE_CYCLES > 0) begin
          settle_nxt = '0;
          state_nxt  = ST_SETTLE;
        end else begin
          ready_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
`else
        ready_nxt = 1'b1;
        state_nxt = ST_IDLE;
`endif
      end

`ifdef VECTOR_SETTLE_EN
      ST_SETTLE: begin
        if (settle_cnt == SET_LAST) begin
          ready_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end
`endif

      default: begin
        beam_nxt  = 1'b0;
        ready_nxt = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_line_engine.sv
// ---------------------------------------------------------------------------
// tb_vector_line_engine
// Self-checking bench for vector_line_engine. Instance u_dut runs with
// STEP_DIV = 1 and u_div4 with STEP_DIV = 4. Line traces are compared
// against an integer Bresenham point list, and busy times against
// max(|dx|,|dy|)+1 or the jump hold time.
// ---------------------------------------------------------------------------
module tb_vector_line_engine;

`ifdef VECTOR_SETTLE_EN
  localparam int JB = 1 + 64;
`else
  localparam int JB = 1;
`endif

  typedef struct {
    bit is_jump;
    int x;
    int y;
    int exp_busy;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [11:0] x, y;
  logic        draw, jump;
  logic        ready, beam_on;
  logic [11:0] dac_x, dac_y;

  logic [11:0] x4, y4;
  logic        draw4, jump4;
  logic        ready4, beam4;
  logic [11:0] dac_x4, dac_y4;

  int vectors    = 0;
  int miscompares = 0;
  int cur_x = 0;
  int cur_y = 0;
  int ref_x[$];
  int ref_y[$];
  vec_t tbl[9];

  vector_line_engine #(.COORD_W(12), .STEP_DIV(1), .SETTLE_CYCLES(64)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .y       (y),
    .draw    (draw),
    .jump    (jump),
    .ready   (ready),
    .dac_x   (dac_x),
    .dac_y   (dac_y),
    .beam_on (beam_on)
  );

  vector_line_engine #(.COORD_W(12), .STEP_DIV(4), .SETTLE_CYCLES(64)) u_div4 (
    .clk     (clk),
    .reset   (reset),
    .x       (x4),
    .y       (y4),
    .draw    (draw4),
    .jump    (jump4),
    .ready   (ready4),
    .dac_x   (dac_x4),
    .dac_y   (dac_y4),
    .beam_on (beam4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns to ready.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ideal point list of a line, one entry per lit step, endpoints included.
  task automatic build_ref(input int x0, input int y0, input int x1, input int y1);
    int ddx, ddy, sx, sy, e, e2, px, py;
    ref_x.delete();
    ref_y.delete();
    px  = x0;
    py  = y0;
    ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
    ddy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    e   = ddx + ddy;
    for (int n = 0; n < 10000; n++) begin
      ref_x.push_back(px);
      ref_y.push_back(py);
      if (px == x1 && py == y1) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; px += sx; end
      if (e2 <= ddx) begin e += ddx; py += sy; end
    end
  endtask

  // Issue one request on u_dut (called at a negedge with ready high), follow
  // it until ready returns, and check busy time, per-cycle trace and end state.
  task automatic apply_stimulus(input bit is_jump, input bit both, input int tx,
                                input int ty, input int exp_busy, input string name);
    int low;
    int bad;
    if (!is_jump) build_ref(cur_x, cur_y, tx, ty);
    x    = tx[11:0];
    y    = ty[11:0];
    draw = !is_jump || both;
    jump = is_jump;
    @(negedge clk);
    draw = 1'b0;
    jump = 1'b0;
    low  = 0;
    bad  = 0;
    while (ready == 1'b0 && low < 6000) begin
      if (is_jump) begin
        if (dac_x != tx || dac_y != ty || beam_on != 1'b0) bad++;
      end else begin
        if (low >= ref_x.size() || dac_x != ref_x[low] || dac_y != ref_y[low] ||
            beam_on != 1'b1) bad++;
      end
      low++;
      @(negedge clk);
    end
    check_output({name, " busy"}, low, exp_busy);
    check_output({name, " trace"}, bad, 0);
    check_output({name, " end x"}, int'(dac_x), tx);
    check_output({name, " end y"}, int'(dac_y), ty);
    check_output({name, " end beam"}, int'(beam_on), 0);
    cur_x = tx;
    cur_y = ty;
  endtask

  initial begin
    int low, bad, tx, ty, ax, ay, ex;
    bit is_j;

    tbl[0] = '{1'b0,    0,    0,    1};
    tbl[1] = '{1'b0,    5,    2,    6};
    tbl[2] = '{1'b1,  100,    7,   JB};
    tbl[3] = '{1'b0,  100,    0,    8};
    tbl[4] = '{1'b0,   90,   10,   11};
    tbl[5] = '{1'b0,  130,   25,   41};
    tbl[6] = '{1'b1, 4095, 4095,   JB};
    tbl[7] = '{1'b0,    0,    0, 4096};
    tbl[8] = '{1'b0, 4095,    0, 4096};

    reset = 1'b0;
    x = '0; y = '0; draw = 1'b0; jump = 1'b0;
    x4 = '0; y4 = '0; draw4 = 1'b0; jump4 = 1'b0;

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    check_output("reset ready", int'(ready), 1);
    check_output("reset dac_x", int'(dac_x), 0);
    check_output("reset dac_y", int'(dac_y), 0);
    check_output("reset beam", int'(beam_on), 0);
    reset = 1'b1;
    @(negedge clk);
    check_output("idle ready", int'(ready), 1);
    check_output("idle beam", int'(beam_on), 0);

    // Spec trace of the (0,0)->(5,2) line, checked on the ideal model itself.
    build_ref(0, 0, 5, 2);
    check_output("ref5_2 x3", ref_x[3], 3);
    check_output("ref5_2 y3", ref_y[3], 1);

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++)
      apply_stimulus(tbl[i].is_jump, 1'b0, tbl[i].x, tbl[i].y, tbl[i].exp_busy,
                     $sformatf("tbl%0d", i));

    $display("[TB] draw and jump together");
    apply_stimulus(1'b1, 1'b1, 100, 7, JB, "both");

    $display("[TB] requests while busy");
    apply_stimulus(1'b1, 1'b0, 10, 10, JB, "prejump");
    x = 12'd20; y = 12'd14; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    low = 0;
    while (ready == 1'b0 && low < 100) begin
      if (low == 1) begin jump = 1'b1; x = 12'd7; y = 12'd7; end
      else if (low == 3) begin jump = 1'b0; draw = 1'b1; end
      else begin jump = 1'b0; draw = 1'b0; end
      low++;
      @(negedge clk);
    end
    draw = 1'b0; jump = 1'b0;
    check_output("busy-pulse busy", low, 11);
    check_output("busy-pulse end x", int'(dac_x), 20);
    check_output("busy-pulse end y", int'(dac_y), 14);
    cur_x = 20; cur_y = 14;
    @(negedge clk);
    check_output("busy-pulse still idle", int'(ready), 1);

    $display("[TB] random requests");
    for (int i = 0; i < 24; i++) begin
      is_j = ($urandom_range(0, 3) == 0);
      if (is_j) begin
        tx = int'($urandom_range(0, 4095));
        ty = int'($urandom_range(0, 4095));
        ex = JB;
      end else begin
        tx = cur_x + int'($urandom_range(0, 400)) - 200;
        ty = cur_y + int'($urandom_range(0, 400)) - 200;
        if (tx < 0) tx = 0;
        if (tx > 4095) tx = 4095;
        if (ty < 0) ty = 0;
        if (ty > 4095) ty = 4095;
        ax = (tx > cur_x) ? tx - cur_x : cur_x - tx;
        ay = (ty > cur_y) ? ty - cur_y : cur_y - ty;
        ex = ((ax > ay) ? ax : ay) + 1;
      end
      apply_stimulus(is_j, 1'b0, tx, ty, ex, $sformatf("rnd%0d", i));
    end

    $display("[TB] reset in mid line");
    apply_stimulus(1'b1, 1'b0, 0, 0, JB, "home");
    x = 12'd1000; y = 12'd0; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    repeat (499) @(negedge clk);
    check_output("mid-line x", int'(dac_x), 499);
    #2 reset = 1'b0;
    #1;
    check_output("abort dac_x", int'(dac_x), 0);
    check_output("abort dac_y", int'(dac_y), 0);
    check_output("abort beam", int'(beam_on), 0);
    check_output("abort ready", int'(ready), 1);
    @(negedge clk);
    reset = 1'b1;
    cur_x = 0; cur_y = 0;
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 3, 0, 4, "post-reset");

    $display("[TB] STEP_DIV = 4");
    x4 = 12'd2; y4 = 12'd0; draw4 = 1'b1;
    @(negedge clk);
    draw4 = 1'b0;
    low = 0;
    bad = 0;
    for (int k = 1; k <= 14; k++) begin
      ex = (k <= 4) ? 0 : ((k <= 8) ? 1 : 2);
      if (int'(dac_x4) != ex || dac_y4 != 12'd0) bad++;
      if (int'(beam4) != ((k <= 12) ? 1 : 0)) bad++;
      if (ready4 == 1'b0) low++;
      @(negedge clk);
    end
    check_output("div4 trace", bad, 0);
    check_output("div4 busy", low, 12);
    check_output("div4 end x", int'(dac_x4), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
